// File: rtl/gmem_rd_arbiter_if.sv
// Read-side bundle between N compute masters, the arbiter and the global
// memory model's single-ID AXI read port. The slave modport is the arbiter's
// view; the master modport is the surrounding environment (masters + memory).
interface gmem_rd_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 512,
  parameter int ID_W    = 4
);
  // compute-master side
  logic [N_PORTS*ADDR_W-1:0] m_araddr;
  logic [N_PORTS*8-1:0]      m_arlen;
  logic [N_PORTS-1:0]        m_arvalid;
  logic [N_PORTS-1:0]        m_arready;
  logic [DATA_W-1:0]         m_rdata;
  logic                      m_rlast;
  logic [N_PORTS-1:0]        m_rvalid;
  logic [N_PORTS-1:0]        m_rready;
  // memory-model side
  logic [ADDR_W-1:0]         s_araddr;
  logic [7:0]                s_arlen;
  logic                      s_arvalid;
  logic                      s_arready;
  logic [ID_W-1:0]           s_arid;
  logic [DATA_W-1:0]         s_rdata;
  logic                      s_rlast;
  logic                      s_rvalid;
  logic                      s_rready;
  logic [ID_W-1:0]           s_rid;

  modport slave (
    input  m_araddr, m_arlen, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rlast, m_rvalid,
    output s_araddr, s_arlen, s_arvalid, s_arid, s_rready,
    input  s_arready, s_rdata, s_rlast, s_rvalid, s_rid
  );

  modport master (
    output m_araddr, m_arlen, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rlast, m_rvalid,
    input  s_araddr, s_arlen, s_arvalid, s_arid, s_rready,
    output s_arready, s_rdata, s_rlast, s_rvalid, s_rid
  );
endinterface

// File: rtl/gmem_rd_arbiter.sv
// Round-robin read arbiter for the global memory model's single-ID AXI port.
// One burst in flight at a time; R beats are steered back to the granted
// master from the registered owner, and the returned beat count is checked
// against the granted arlen (sticky len_err).
module gmem_rd_arbiter #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 512,
  parameter int ID_W    = 4
) (
  input  logic              clk,
  input  logic              nrst,
  gmem_rd_arbiter_if.slave  bus,
  output logic              busy,
  output logic              len_err
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   win;
  logic [PTR_W:0]     arb_idx;
  logic               arb_found;
  logic               req_any;
  logic [7:0]         exp_len;
  logic [8:0]         beat_cnt;
  logic [ADDR_W-1:0]  araddr_q;
  logic [7:0]         arlen_q;
  logic               arvalid_q;
  logic [N_PORTS-1:0] arready_q;
  logic               r_hs;
  logic               unused_rid;

  // The memory model is driven with a single ID, so the returned ID carries no information.
  assign unused_rid = ^bus.s_rid;

  assign req_any       = |bus.m_arvalid;
  assign busy          = (state != IDLE);
  assign bus.s_araddr  = araddr_q;
  assign bus.s_arlen   = arlen_q;
  assign bus.s_arvalid = arvalid_q;
  assign bus.s_arid    = '0;
  assign bus.m_arready = arready_q;
  assign bus.m_rdata   = bus.s_rdata;
  assign r_hs          = (state == DATA) && bus.s_rvalid && bus.m_rready[owner];

  // Round-robin pick: first requesting port at or above rr_ptr, wrapping.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    win       = rr_ptr;
    for (int i = 0; i < N_PORTS; i++) begin
      arb_idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (arb_idx >= (PTR_W+1)'(N_PORTS)) arb_idx = arb_idx - (PTR_W+1)'(N_PORTS);
      if (!arb_found && bus.m_arvalid[arb_idx[PTR_W-1:0]]) begin
        arb_found = 1'b1;
        win       = arb_idx[PTR_W-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (nrst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and R-channel steering; R is only routed while a burst owns the port.
  always_comb begin
    state_nxt     = state;
    bus.m_rvalid  = '0;
    bus.s_rready  = 1'b0;
    bus.m_rlast   = 1'b0;
    case (state)
      IDLE: if (req_any) state_nxt = ADDR;
      ADDR: if (bus.s_arready) state_nxt = DATA;
      DATA: begin
        bus.m_rvalid[owner] = bus.s_rvalid;
        bus.s_rready        = bus.m_rready[owner];
        bus.m_rlast         = bus.s_rlast;
        if (r_hs && bus.s_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, AR hold, beat counting and length check.
  always_ff @(posedge clk) begin
    if (nrst) begin
      rr_ptr    <= '0;
      owner     <= '0;
      exp_len   <= '0;
      beat_cnt  <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      arready_q <= '0;
      len_err   <= 1'b0;
    end else begin
      // m_arready is a one-cycle pulse; the master still holds its request during it.
      arready_q <= '0;
      case (state)
        IDLE: if (req_any) begin
          owner     <= win;
          exp_len   <= bus.m_arlen[win*8 +: 8];
          araddr_q  <= bus.m_araddr[win*ADDR_W +: ADDR_W];
          arlen_q   <= bus.m_arlen[win*8 +: 8];
          arvalid_q <= 1'b1;
          arready_q <= N_PORTS'(1) << win;
          rr_ptr    <= (win == PTR_W'(N_PORTS-1)) ? '0 : win + 1'b1;
        end
        ADDR: if (bus.s_arready) begin
          arvalid_q <= 1'b0;
          beat_cnt  <= '0;
        end
        DATA: if (r_hs) begin
          beat_cnt <= beat_cnt + 9'd1;
          // Early rlast, late rlast and overrun all compare pre-increment count.
          if (bus.s_rlast) begin
            if (beat_cnt != {1'b0, exp_len}) len_err <= 1'b1;
          end else if (beat_cnt == {1'b0, exp_len}) begin
            len_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gmem_rd_arbiter.sv
// Bench for gmem_rd_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_gmem_rd_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 512;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic nrst;
  logic busy, len_err;

  gmem_rd_arbiter_if #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();

  gmem_rd_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .bus     (bus),
    .busy    (busy),
    .len_err (len_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // masters
  bit          pend[N];
  logic [AW-1:0] p_addr[N];
  logic [7:0]  p_len[N];
  int          beats_to[N];
  // reference model
  bit          m_busy, m_ar_wait, exp_err;
  int          tb_ptr, own, beats;
  logic [AW-1:0] g_addr;
  logic [7:0]  g_len;
  logic [N-1:0] grant_vec;
  int          grant_log[$];
  // memory slave
  int          s_left;
  int          nbeats_ovr = -1;
  // knobs
  bit          auto_req;
  int          req_pct, len_max, arready_pct, rvalid_pct, rready_pct, err_pct;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit any_pend();
    bit a = 1'b0;
    for (int p = 0; p < N; p++) a |= pend[p];
    return a;
  endfunction

  task automatic drive_masters();
    for (int p = 0; p < N; p++) begin
      bus.m_arvalid[p]          = pend[p];
      bus.m_araddr[p*AW +: AW]  = p_addr[p];
      bus.m_arlen[p*8 +: 8]     = p_len[p];
    end
  endtask

  task automatic req(int p, logic [AW-1:0] a, logic [7:0] l);
    pend[p] = 1'b1; p_addr[p] = a; p_len[p] = l;
    drive_masters();
  endtask

  // Compare every output against what the model says this cycle should show.
  task automatic check_outputs();
    bit data;
    logic [N-1:0] ev;
    data = m_busy && !m_ar_wait;
    ev = '0;
    if (data && bus.s_rvalid) ev[own] = 1'b1;
    chk("m_arready", DW'(bus.m_arready), DW'(grant_vec));
    chk("s_arvalid", DW'(bus.s_arvalid), DW'(m_busy && m_ar_wait));
    if (m_busy && m_ar_wait) begin
      chk("s_araddr", DW'(bus.s_araddr), DW'(g_addr));
      chk("s_arlen", DW'(bus.s_arlen), DW'(g_len));
    end
    chk("s_arid", DW'(bus.s_arid), DW'(0));
    chk("busy", DW'(busy), DW'(m_busy));
    chk("len_err", DW'(len_err), DW'(exp_err));
    chk("m_rvalid", DW'(bus.m_rvalid), DW'(ev));
    chk("s_rready", DW'(bus.s_rready), DW'(data ? bus.m_rready[own] : 1'b0));
    chk("m_rlast", DW'(bus.m_rlast), DW'(data & bus.s_rlast));
    chk("m_rdata", bus.m_rdata, bus.s_rdata);
  endtask

  // Advance the model over the edge just taken, then drive the next cycle's inputs.
  task automatic after_edge();
    logic [N-1:0] arv, gv;
    bit rst, ar_hs, r_hs;
    int g, c;
    arv   = bus.m_arvalid;
    gv    = grant_vec;
    rst   = nrst;
    ar_hs = m_busy && m_ar_wait && bus.s_arready;
    r_hs  = m_busy && !m_ar_wait && bus.s_rvalid && bus.m_rready[own];
    grant_vec = '0;
    for (int p = 0; p < N; p++) if (gv[p]) pend[p] = 1'b0;
    if (rst) begin
      m_busy = 0; m_ar_wait = 0; tb_ptr = 0; exp_err = 0; s_left = 0;
      bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0;
    end else if (!m_busy) begin
      if (arv != '0) begin
        g = -1;
        for (int i = 0; i < N; i++) begin
          c = (tb_ptr + i) % N;
          if (g < 0 && arv[c]) g = c;
        end
        own = g; g_addr = p_addr[g]; g_len = p_len[g];
        grant_vec[g] = 1'b1; tb_ptr = (g + 1) % N;
        m_busy = 1; m_ar_wait = 1;
        grant_log.push_back(g);
      end
    end else if (m_ar_wait) begin
      if (ar_hs) begin
        m_ar_wait = 0; beats = 0;
        if (nbeats_ovr > 0) begin s_left = nbeats_ovr; nbeats_ovr = -1; end
        else if ($urandom_range(99) < err_pct) s_left = $urandom_range(int'(g_len) + 3, 1);
        else s_left = int'(g_len) + 1;
      end
    end else if (r_hs) begin
      beats_to[own]++;
      if (bus.s_rlast) begin
        if (beats != int'(g_len)) exp_err = 1;
        m_busy = 0;
      end else if (beats == int'(g_len)) begin
        exp_err = 1;
      end
      beats++; s_left--;
      bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0;
    end
    if (auto_req)
      for (int p = 0; p < N; p++)
        if (!pend[p] && $urandom_range(99) < req_pct) begin
          pend[p] = 1'b1;
          p_addr[p] = $urandom & 32'hffff_ffc0;
          p_len[p] = 8'($urandom_range(len_max));
        end
    drive_masters();
    bus.s_arready = ($urandom_range(99) < arready_pct);
    for (int p = 0; p < N; p++) bus.m_rready[p] = ($urandom_range(99) < rready_pct);
    if (s_left > 0 && !bus.s_rvalid && $urandom_range(99) < rvalid_pct) begin
      bus.s_rvalid = 1'b1;
      bus.s_rdata  = rnd_data();
      bus.s_rlast  = (s_left == 1);
    end
    bus.s_rid = IW'($urandom);
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    after_edge();
  endtask

  task automatic do_reset(int n);
    nrst = 1'b1;
    repeat (n) step();
    nrst = 1'b0;
  endtask

  task automatic drain(int max);
    int n = 0;
    bit to;
    while ((m_busy || any_pend()) && n < max) begin step(); n++; end
    to = m_busy || any_pend();
    chk("drain_timeout", DW'(to), DW'(0));
    step();
  endtask

  task automatic wait_beats(int k, int max);
    int n = 0;
    bit to;
    while (!(m_busy && !m_ar_wait && beats >= k) && n < max) begin step(); n++; end
    to = !(m_busy && !m_ar_wait && beats >= k);
    chk("beat_wait_timeout", DW'(to), DW'(0));
  endtask

  initial begin
    int b0;
    int exp_order[5];
    nrst = 1'b1;
    bus.m_araddr = '0; bus.m_arlen = '0; bus.m_arvalid = '0; bus.m_rready = '0;
    bus.s_arready = 1'b0; bus.s_rdata = '0; bus.s_rlast = 1'b0; bus.s_rvalid = 1'b0; bus.s_rid = '0;
    for (int p = 0; p < N; p++) begin pend[p] = 0; p_addr[p] = '0; p_len[p] = '0; beats_to[p] = 0; end
    m_busy = 0; m_ar_wait = 0; exp_err = 0; tb_ptr = 0; own = 0; beats = 0;
    g_addr = '0; g_len = '0; grant_vec = '0; s_left = 0;
    auto_req = 0; req_pct = 0; len_max = 0; err_pct = 0;
    arready_pct = 100; rvalid_pct = 100; rready_pct = 100;
    @(posedge clk); #1; after_edge();
    step(); step();
    nrst = 1'b0;
    step();

    // single burst on port 2, slave always ready
    b0 = beats_to[2];
    req(2, 32'h1000_0040, 8'd3);
    drain(50);
    chk("t1_beats_port2", DW'(beats_to[2] - b0), DW'(4));

    // all ports request arlen=0 continuously from reset
    do_reset(1);
    grant_log.delete();
    for (int p = 0; p < N; p++) req(p, 32'h0000_1000 + 32'(p*64), 8'd0);
    auto_req = 1; req_pct = 100; len_max = 0;
    repeat (30) step();
    auto_req = 0;
    drain(60);
    exp_order = '{0, 1, 2, 3, 0};
    chk("t2_grant_count", DW'(grant_log.size() >= 5), DW'(1));
    if (grant_log.size() >= 5)
      for (int i = 0; i < 5; i++) chk("t2_grant_order", DW'(grant_log[i]), DW'(exp_order[i]));

    // owner back-pressures R for 3 cycles mid-burst
    b0 = beats_to[1];
    req(1, 32'h2000_0100, 8'd5);
    wait_beats(2, 40);
    rready_pct = 0; bus.m_rready = '0;
    repeat (3) step();
    rready_pct = 100; bus.m_rready = '1;
    drain(50);
    chk("t3_beats_port1", DW'(beats_to[1] - b0), DW'(6));

    // slave stalls AR for several cycles
    arready_pct = 0; bus.s_arready = 1'b0;
    req(0, 32'h3000_0200, 8'd2);
    repeat (7) step();
    chk("t4_arvalid_held", DW'(bus.s_arvalid), DW'(1));
    chk("t4_no_rvalid", DW'(bus.m_rvalid), DW'(0));
    arready_pct = 100;
    drain(50);

    // early rlast: arlen=3 but only 2 beats returned
    nbeats_ovr = 2;
    req(2, 32'h4000_0000, 8'd3);
    drain(50);
    chk("t5_len_err_set", DW'(len_err), DW'(1));
    b0 = beats_to[3];
    req(3, 32'h4000_0400, 8'd1);
    drain(50);
    chk("t5_len_err_sticky", DW'(len_err), DW'(1));
    chk("t5_next_served", DW'(beats_to[3] - b0), DW'(2));

    // reset lands mid-burst, then a fresh request is served
    do_reset(1);
    req(0, 32'h5000_0000, 8'd7);
    wait_beats(1, 40);
    nrst = 1'b1;
    step();
    nrst = 1'b0;
    chk("t6_busy_after_rst", DW'(busy), DW'(0));
    chk("t6_len_err_after_rst", DW'(len_err), DW'(0));
    step();
    b0 = beats_to[3];
    req(3, 32'h6000_0080, 8'd2);
    drain(50);
    chk("t6_port3_served", DW'(beats_to[3] - b0), DW'(3));

    // randomized traffic with occasional wrong beat counts and resets
    auto_req = 1; err_pct = 15; len_max = 7;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset(2);
      req_pct     = $urandom_range(80, 10);
      arready_pct = $urandom_range(90, 30);
      rvalid_pct  = $urandom_range(95, 30);
      rready_pct  = $urandom_range(95, 30);
      repeat (600) step();
    end
    auto_req = 0; arready_pct = 100; rvalid_pct = 100; rready_pct = 100;
    drain(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
